// File: rtl/tkz_revert_ctrl_32b_pkg.sv
// ---------------------------------------------------------------------------
// tkz_revert_pkg
// Shared definitions for the tweakey-lane revert controller and the
// Romulus-N core FSM that calls it once per block.
//   - DEF_ROUNDS / DEF_CYC_PER_ROUND : default SKINNY-128-384+ schedule on the
//     32-bit masked datapath (40 rounds x 4 cycles).
//   - tkz_state_e : controller state encoding (IDLE, RUN, REVERT).
//   - CNT_W()     : width of a counter that must reach total-1.
// No ports; this is a package.
// ---------------------------------------------------------------------------
package tkz_revert_pkg;

  localparam int DEF_ROUNDS        = 40;
  localparam int DEF_CYC_PER_ROUND = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REVERT = 2'd2
  } tkz_state_e;

  // Width needed to count 0 .. total-1. A total of one or two still gets a
  // single bit so the counter never collapses to a zero-width vector.
  function automatic int CNT_W(input int total);
    if (total <= 2) begin
      return 1;
    end
    return $clog2(total);
  endfunction

endpackage

// File: rtl/tkz_revert_ctrl_32b_if.sv
// ---------------------------------------------------------------------------
// tkz_revert_ctrl_32b_if
// Bundle between the core FSM (master) and the tweakey revert controller
// (slave).
//   start             : master -> slave, begin a block (taken only in IDLE)
//   halt              : master -> slave, pause the run
//   abort             : master -> slave, end the run early
//   tkz[63:0]         : master -> slave, live tweakey-lane contents
//   skinny_tkz_revert : slave -> master, registered snapshot of the lane
//   enc               : slave -> master, lane update enable
//   se                : slave -> master, 1 = reload snapshot, 0 = round update
//   busy              : slave -> master, high in RUN and REVERT
//   done              : slave -> master, one-cycle pulse in REVERT
// ---------------------------------------------------------------------------
interface tkz_revert_ctrl_32b_if;

  logic        start;
  logic        halt;
  logic        abort;
  logic [63:0] tkz;
  logic [63:0] skinny_tkz_revert;
  logic        enc;
  logic        se;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output halt,
    output abort,
    output tkz,
    input  skinny_tkz_revert,
    input  enc,
    input  se,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  halt,
    input  abort,
    input  tkz,
    output skinny_tkz_revert,
    output enc,
    output se,
    output busy,
    output done
  );

endinterface

// File: rtl/tkz_revert_ctrl_32b_run_cnt.sv
// ---------------------------------------------------------------------------
// tkz_run_cnt
// Up-counter that walks through one SKINNY run. It is reloaded to zero when a
// block is accepted, advances on every enabled cycle and flags the last run
// cycle on tc_o.
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   clear_i  : load zero (wins over enable_i)
//   enable_i : advance by one
//   tc_o     : count equals TOTAL-1
// ---------------------------------------------------------------------------
module tkz_run_cnt
  import tkz_revert_pkg::*;
#(
  parameter int TOTAL = DEF_ROUNDS * DEF_CYC_PER_ROUND,
  parameter int W     = CNT_W(TOTAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [W-1:0] TcVal = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a clear reloads zero, otherwise advance while enabled. The
  // counter parks on the terminal value instead of wrapping, so an
  // extra enabled cycle after tc can never alias back to an early count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != TcVal)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared straight away by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count marks the final cycle of the run.
  assign tc_o = (count_q == TcVal);

endmodule

// File: rtl/tkz_revert_ctrl_32b.sv
// ---------------------------------------------------------------------------
// tkz_revert_ctrl_32b
// Sending-side controller for the tweakey-lane register of the 32-bit masked
// SKINNY datapath. On start it snapshots the 64-bit lane and enables the lane
// update for every cycle of a SKINNY run. The run ends with one REVERT cycle
// that selects the snapshot path (se=1) with enc=1, so the lane goes back to
// its pre-block value ready for the next Romulus block.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : tkz_revert_ctrl_32b_if.slave
//          in : start, halt, abort, tkz[63:0]
//          out: skinny_tkz_revert[63:0], enc, se, busy, done
// Parameters:
//   ROUNDS        : SKINNY round count
//   CYC_PER_ROUND : datapath cycles per round
// ---------------------------------------------------------------------------
module tkz_revert_ctrl_32b
  import tkz_revert_pkg::*;
#(
  parameter int ROUNDS        = DEF_ROUNDS,
  parameter int CYC_PER_ROUND = DEF_CYC_PER_ROUND
) (
  input  logic                  clk,
  input  logic                  rst,
  tkz_revert_ctrl_32b_if.slave  bus
);

  localparam int TotalCyc = ROUNDS * CYC_PER_ROUND;
  localparam int CntW     = CNT_W(TotalCyc);

  tkz_state_e  state_q;
  logic [63:0] snapshot_q;
  logic        busy_q;
  logic        se_q;
  logic        done_q;

  logic        startAccept;
  logic        runAdvance;
  logic        runTc;

  // A start only counts in IDLE; anywhere else it is dropped, not queued.
  assign startAccept = (state_q == IDLE) && bus.start;

  // The run counter advances on RUN cycles that are neither halted nor
  // aborted; an abort leaves RUN on the next edge so its count is irrelevant.
  assign runAdvance = (state_q == RUN) && !bus.halt && !bus.abort;

  tkz_run_cnt #(
    .TOTAL (TotalCyc),
    .W     (CntW)
  ) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (startAccept),
    .enable_i (runAdvance),
    .tc_o     (runTc)
  );

  // Controller FSM. busy/se/done are registered alongside the state so they
  // come straight off flops. The snapshot is loaded only when a start is
  // accepted and otherwise holds through RUN, REVERT and IDLE, so replaying
  // REVERT always restores the same pre-block lane value. Abort beats halt;
  // the terminal count only ends the run on a non-halted cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      snapshot_q <= '0;
      busy_q     <= 1'b0;
      se_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            snapshot_q <= bus.tkz;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort || (!bus.halt && runTc)) begin
            state_q <= REVERT;
            se_q    <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        REVERT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          se_q    <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          se_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // enc is the one output with a path from an input: during RUN it drops in
  // the very cycle halt is raised, so a paused lane is not clocked. In REVERT
  // se_q is set and enc is forced high to load the snapshot.
  assign bus.enc               = se_q | (busy_q & ~bus.halt);
  assign bus.se                = se_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.skinny_tkz_revert = snapshot_q;

endmodule
